dmem_store_buffer: RTL and testbench

//  Store buffer between the pipelined core's MEM stage and a single-port, handshaked data memory.

---
 rtl/dmem_store_buffer.sv | 181 ++++++++++++++++++
 tb/tb_dmem_store_buffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer.sv
// Store buffer between the MEM stage and a single-port handshaked data memory: posts stores,
// drains them in the background, forwards buffered data to loads. Option: STBUF_COALESCE_EN.
module dmem_store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwritem,
    input  logic          memreadm,
    input  logic [AW-1:0] aluoutm,
    input  logic [31:0]   writedatam,
    output logic [31:0]   readdata,
    output logic          stallm,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ready,
    input  logic [31:0]   mem_rdata
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned WA = AW - 2;

    typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

    state_e        state_q, state_d;
    logic [WA-1:0] addr_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [PW:0]   count_q, count_d;

    logic [WA-1:0] word;
    logic          store_req, full, enq, deq, coalesce;
    logic          fwd_hit, load_hit, load_miss, load_done;
    logic          issue_load, issue_drain;
    logic [31:0]   fwd_data;
    logic [PW-1:0] slot;
    logic          unused_lsb;

    assign word       = aluoutm[AW-1:2];
    assign unused_lsb = ^aluoutm[1:0];
    assign store_req  = memwritem & ~memreadm;
    assign full       = (count_q == (PW+1)'(DEPTH));
    assign enq        = store_req & ~full & ~coalesce;
    assign load_hit   = memreadm & fwd_hit;
    assign load_miss  = memreadm & ~fwd_hit;
    assign deq        = issue_drain & mem_ready;
    assign load_done  = issue_load & mem_ready;
    assign count_d    = count_q + (PW+1)'(enq) - (PW+1)'(deq);

    // Walk entries oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        slot     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head_q + PW'(i);
            if (((PW+1)'(i) < count_q) && (addr_q[slot] == word)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[slot];
            end
        end
    end

`ifdef STBUF_COALESCE_EN
    logic          coal_hit, head_busy;
    logic [PW-1:0] coal_idx, coal_slot;

    // The head is off limits whenever its write is on the bus, since it may complete this cycle.
    assign head_busy = (state_q == StDrain) || ((state_q == StIdle) && (count_q != '0));

    always_comb begin
        coal_hit  = 1'b0;
        coal_idx  = '0;
        coal_slot = '0;
        for (int i = 0; i < DEPTH; i++) begin
            coal_slot = head_q + PW'(i);
            if (((PW+1)'(i) < count_q) && (addr_q[coal_slot] == word) &&
                !((i == 0) && head_busy)) begin
                coal_hit = 1'b1;
                coal_idx = coal_slot;
            end
        end
    end

    assign coalesce = store_req & coal_hit;
`else
    assign coalesce = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= word;
            data_q[tail_q] <= writedatam;
        end
`ifdef STBUF_COALESCE_EN
        if (coalesce) begin
            data_q[coal_idx] <= writedatam;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq) tail_q <= tail_q + 1'b1;
            if (deq) head_q <= head_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // IDLE issues its chosen request combinationally; LOAD/DRAIN hold it until mem_ready.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (load_miss && !mem_ready) begin
                    state_d = StLoad;
                end else if (!load_miss && (count_q != '0) && !mem_ready) begin
                    state_d = StDrain;
                end
            end
            StLoad: begin
                if (mem_ready) state_d = StIdle;
            end
            StDrain: begin
                if (mem_ready) begin
                    state_d = ((count_d != '0) && !load_miss) ? StDrain : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        issue_load  = 1'b0;
        issue_drain = 1'b0;
        unique case (state_q)
            StIdle: begin
                issue_load  = load_miss;
                issue_drain = !load_miss && (count_q != '0);
            end
            StLoad:  issue_load  = 1'b1;
            StDrain: issue_drain = 1'b1;
            default: ;
        endcase

        mem_req   = reset & (issue_load | issue_drain);
        mem_we    = reset & issue_drain;
        mem_addr  = '0;
        mem_wdata = '0;
        if (reset && issue_drain) begin
            mem_addr  = {addr_q[head_q], 2'b00};
            mem_wdata = data_q[head_q];
        end else if (reset && issue_load) begin
            mem_addr = {word, 2'b00};
        end

        stallm   = reset & ((store_req & full & ~coalesce) | (load_miss & ~load_done));
        readdata = '0;
        if (reset && load_hit) begin
            readdata = fwd_data;
        end else if (reset && load_done) begin
            readdata = mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer: per-cycle vector tables plus hand sequences for reset,
// full-buffer stall, load-miss arbitration and a randomised drain across pointer wrap.
module tb_dmem_store_buffer;

    logic        clk, reset;
    logic        memwritem, memreadm, mem_ready;
    logic [31:0] aluoutm, writedatam, mem_rdata;
    logic [31:0] readdata, mem_addr, mem_wdata;
    logic        stallm, mem_req, mem_we;

    dmem_store_buffer #(.DEPTH(4), .AW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .memwritem  (memwritem),
        .memreadm   (memreadm),
        .aluoutm    (aluoutm),
        .writedatam (writedatam),
        .readdata   (readdata),
        .stallm     (stallm),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we, re;
        logic [31:0] addr, wd;
        logic        rdy;
        logic [31:0] rdat;
        logic        xs, xr, xw;
        logic [31:0] xa, xd;
        logic        crd;
        logic [31:0] xrd;
    } vec_t;

    vec_t        tv[$];
    logic [63:0] wlog[$];
    logic [63:0] exp_q[$];
    int          base;
    int          errors = 0;
    int          checks = 0;

    always @(posedge clk) begin
        if (reset && mem_req && mem_we && mem_ready) wlog.push_back({mem_addr, mem_wdata});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic re, input logic [31:0] addr,
                                input logic [31:0] wd, input logic rdy, input logic [31:0] rdat,
                                input logic xs, input logic xr, input logic xw,
                                input logic [31:0] xa, input logic [31:0] xd,
                                input logic crd, input logic [31:0] xrd);
        vec_t v;
        v.we = we; v.re = re; v.addr = addr; v.wd = wd; v.rdy = rdy; v.rdat = rdat;
        v.xs = xs; v.xr = xr; v.xw = xw; v.xa = xa; v.xd = xd; v.crd = crd; v.xrd = xrd;
        return v;
    endfunction

    task automatic idle(input logic rdy);
        memwritem = 1'b0; memreadm = 1'b0; aluoutm = '0; writedatam = '0;
        mem_ready = rdy; mem_rdata = '0;
    endtask

    task automatic apply(input vec_t v, input int t, input int c);
        memwritem = v.we; memreadm = v.re; aluoutm = v.addr; writedatam = v.wd;
        mem_ready = v.rdy; mem_rdata = v.rdat;
        @(negedge clk);
        chk($sformatf("t%0d.c%0d.stallm", t, c), {31'b0, stallm}, {31'b0, v.xs});
        chk($sformatf("t%0d.c%0d.mem_req", t, c), {31'b0, mem_req}, {31'b0, v.xr});
        if (v.xr) begin
            chk($sformatf("t%0d.c%0d.mem_we", t, c), {31'b0, mem_we}, {31'b0, v.xw});
            chk($sformatf("t%0d.c%0d.mem_addr", t, c), mem_addr, v.xa);
            if (v.xw) chk($sformatf("t%0d.c%0d.mem_wdata", t, c), mem_wdata, v.xd);
        end
        if (v.crd) chk($sformatf("t%0d.c%0d.readdata", t, c), readdata, v.xrd);
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input int t);
        foreach (tv[i]) apply(tv[i], t, i);
        tv.delete();
    endtask

    task automatic do_reset(input bit check_out);
        idle(1'b0);
        reset = 1'b0;
        #3;
        if (check_out) begin
            chk("reset.mem_req", {31'b0, mem_req}, 32'd0);
            chk("reset.mem_we", {31'b0, mem_we}, 32'd0);
            chk("reset.mem_addr", mem_addr, 32'd0);
            chk("reset.mem_wdata", mem_wdata, 32'd0);
            chk("reset.stallm", {31'b0, stallm}, 32'd0);
            chk("reset.readdata", readdata, 32'd0);
            chk("reset.count", 32'(dut.count_q), 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        base  = wlog.size();
    endtask

    task automatic drain_all(input int t);
        int n;
        idle(1'b1);
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            if (dut.count_q == '0) break;
            n++;
        end
        chk($sformatf("t%0d.drain_done", t), 32'(dut.count_q), 32'd0);
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_log(input int t);
        chk($sformatf("t%0d.nwrites", t), 32'(wlog.size() - base), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (base + i < wlog.size()) begin
                chk($sformatf("t%0d.w%0d.addr", t, i), wlog[base+i][63:32], exp_q[i][63:32]);
                chk($sformatf("t%0d.w%0d.data", t, i), wlog[base+i][31:0], exp_q[i][31:0]);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        int          n;
        logic        acc;
        logic [31:0] d;

        do_reset(1'b1);

        // 1: async reset while a drain is in flight with three entries buffered.
        tv.push_back(mk(1, 0, 32'h10, 32'h1111_1111, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 0, 32'h14, 32'h2222_2222, 0, 0, 0, 1, 1, 32'h10, 32'h1111_1111, 0, 0));
        tv.push_back(mk(1, 0, 32'h18, 32'h3333_3333, 0, 0, 0, 1, 1, 32'h10, 32'h1111_1111, 0, 0));
        tv.push_back(mk(0, 0, 32'h0, 32'h0, 0, 0, 0, 1, 1, 32'h10, 32'h1111_1111, 0, 0));
        run_table(1);
        chk("t1.count_before", 32'(dut.count_q), 32'd3);
        chk("t1.req_before", {31'b0, mem_req}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t1.mem_req", {31'b0, mem_req}, 32'd0);
        chk("t1.stallm", {31'b0, stallm}, 32'd0);
        chk("t1.count", 32'(dut.count_q), 32'd0);
        check_log(1);

        // 2: forward a just-posted store while its drain write is on the bus.
        do_reset(1'b0);
        tv.push_back(mk(1, 0, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 1, 32'h100, 32'h0, 0, 0, 0, 1, 1, 32'h100, 32'hDEAD_BEEF,
                        1, 32'hDEAD_BEEF));
        run_table(2);

        // 3: fill to DEPTH, fifth store stalls until a slot is freed on an edge.
        do_reset(1'b0);
        tv.push_back(mk(1, 0, 32'h10, 32'hA0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 0, 32'h14, 32'hA1, 0, 0, 0, 1, 1, 32'h10, 32'hA0, 0, 0));
        tv.push_back(mk(1, 0, 32'h18, 32'hA2, 0, 0, 0, 1, 1, 32'h10, 32'hA0, 0, 0));
        tv.push_back(mk(1, 0, 32'h1C, 32'hA3, 0, 0, 0, 1, 1, 32'h10, 32'hA0, 0, 0));
        tv.push_back(mk(1, 0, 32'h20, 32'hA4, 0, 0, 1, 1, 1, 32'h10, 32'hA0, 0, 0));
        tv.push_back(mk(1, 0, 32'h20, 32'hA4, 1, 0, 1, 1, 1, 32'h10, 32'hA0, 0, 0));
        tv.push_back(mk(1, 0, 32'h20, 32'hA4, 0, 0, 0, 1, 1, 32'h14, 32'hA1, 0, 0));
        tv.push_back(mk(0, 0, 32'h0, 32'h0, 0, 0, 0, 1, 1, 32'h14, 32'hA1, 0, 0));
        run_table(3);
        chk("t3.count_full", 32'(dut.count_q), 32'd4);
        drain_all(3);
        exp_q.push_back({32'h10, 32'hA0}); exp_q.push_back({32'h14, 32'hA1});
        exp_q.push_back({32'h18, 32'hA2}); exp_q.push_back({32'h1C, 32'hA3});
        exp_q.push_back({32'h20, 32'hA4});
        check_log(3);

        // 4: load miss waits for the in-flight drain, then beats the next drain.
        do_reset(1'b0);
        tv.push_back(mk(1, 0, 32'h30, 32'hB0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 0, 32'h34, 32'hB1, 0, 0, 0, 1, 1, 32'h30, 32'hB0, 0, 0));
        tv.push_back(mk(1, 0, 32'h38, 32'hB2, 0, 0, 0, 1, 1, 32'h30, 32'hB0, 0, 0));
        tv.push_back(mk(0, 1, 32'h200, 32'h0, 1, 0, 1, 1, 1, 32'h30, 32'hB0, 0, 0));
        tv.push_back(mk(0, 1, 32'h200, 32'h0, 0, 0, 1, 1, 0, 32'h200, 0, 0, 0));
        tv.push_back(mk(0, 1, 32'h200, 32'h0, 0, 0, 1, 1, 0, 32'h200, 0, 0, 0));
        tv.push_back(mk(0, 1, 32'h200, 32'h0, 1, 32'h1234_5678, 0, 1, 0, 32'h200, 0,
                        1, 32'h1234_5678));
        tv.push_back(mk(0, 0, 32'h0, 32'h0, 0, 0, 0, 1, 1, 32'h34, 32'hB1, 0, 0));
        run_table(4);
        chk("t4.count", 32'(dut.count_q), 32'd2);
        drain_all(4);
        exp_q.push_back({32'h30, 32'hB0}); exp_q.push_back({32'h34, 32'hB1});
        exp_q.push_back({32'h38, 32'hB2});
        check_log(4);

        // 5: repeated store to one word behind an in-flight head write.
        do_reset(1'b0);
        tv.push_back(mk(1, 0, 32'h44, 32'hC0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 0, 32'h40, 32'h1, 0, 0, 0, 1, 1, 32'h44, 32'hC0, 0, 0));
        tv.push_back(mk(1, 0, 32'h40, 32'h2, 0, 0, 0, 1, 1, 32'h44, 32'hC0, 0, 0));
        tv.push_back(mk(0, 1, 32'h40, 32'h0, 0, 0, 0, 1, 1, 32'h44, 32'hC0, 1, 32'h2));
        run_table(5);
        exp_q.push_back({32'h44, 32'hC0});
`ifdef STBUF_COALESCE_EN
        chk("t5.count", 32'(dut.count_q), 32'd2);
`else
        chk("t5.count", 32'(dut.count_q), 32'd3);
        exp_q.push_back({32'h40, 32'h1});
`endif
        exp_q.push_back({32'h40, 32'h2});
        drain_all(5);
        check_log(5);

        // 6: 2*DEPTH+1 stores with random mem_ready, order kept across pointer wrap.
        do_reset(1'b0);
        for (int i = 0; i < 9; i++) begin
            d = $urandom;
            exp_q.push_back({32'h300 + 32'(4 * i), d});
            memwritem = 1'b1; memreadm = 1'b0; aluoutm = 32'h300 + 32'(4 * i); writedatam = d;
            acc = 1'b0;
            n   = 0;
            while (!acc && n < 40) begin
                mem_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                acc = ~stallm;
                @(posedge clk);
                #1;
                n++;
            end
            if (!acc) begin
                errors++;
                $display("FAIL t6.accept%0d: store never accepted in %0d cycles", i, n);
            end
        end
        idle(1'b0);
        n = 0;
        while (n < 200) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (dut.count_q == '0) break;
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6.count", 32'(dut.count_q), 32'd0);
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        check_log(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
